// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: next-PC select codes and defaults.
package pc_pkg;

   localparam int          DEF_WIDTH   = 32;
   localparam int          DEF_INC     = 4;
   localparam logic [31:0] DEF_EXC_VEC = 32'h0000_0080;

   typedef enum logic [2:0] {
      SEL_RST,
      SEL_EXC,
      SEL_BR,
      SEL_HOLD,
      SEL_JMP,
      SEL_RET,
      SEL_SEQ
   } pc_sel_e;

   // Any source other than hold/sequential/reset flushes IF/ID on the next cycle.
   function automatic logic is_redirect(pc_sel_e sel);
      return sel inside {SEL_EXC, SEL_BR, SEL_JMP, SEL_RET};
   endfunction

endpackage

// File: rtl/pc_if.sv
// Redirect sources into, and fetch address/status out of, the program-counter unit.
interface pc_if #(parameter int WIDTH = pc_pkg::DEF_WIDTH);

   logic             stall;
   logic             exc;
   logic [WIDTH-1:0] exc_pc;
   logic             br_taken;
   logic [WIDTH-1:0] br_target;
   logic             jump;
   logic [WIDTH-1:0] jump_target;
   logic             call;
   logic [WIDTH-1:0] call_ret_addr;
   logic             ret;
   logic [WIDTH-1:0] ret_target;
   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] epc;
   logic             redirect;
   logic             ras_empty;

   modport master (
      output stall, exc, exc_pc, br_taken, br_target, jump, jump_target,
             call, call_ret_addr, ret, ret_target,
      input  pc, pc_plus, epc, redirect, ras_empty
   );

   modport slave (
      input  stall, exc, exc_pc, br_taken, br_target, jump, jump_target,
             call, call_ret_addr, ret, ret_target,
      output pc, pc_plus, epc, redirect, ras_empty
   );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// pop on empty is ignored, pop+push replaces the top.
module pc_ras import pc_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic             empty,
   output logic             full
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    sp;      // next free slot; top lives just below it
   logic [PW-1:0]    sp_dec;
   logic [PW-1:0]    sp_inc;
   logic [CW-1:0]    count;
   logic             pop_ok;
   logic             wr_en;

   assign sp_dec = (sp == '0) ? PW'(DEPTH - 1) : sp - PW'(1);
   assign sp_inc = (sp == PW'(DEPTH - 1)) ? '0 : sp + PW'(1);
   assign empty  = (count == '0);
   assign full   = (count == CW'(DEPTH));
   assign top    = mem[sp_dec];
   assign pop_ok = pop && !empty;
   assign wr_en  = push && !rst && !clear;

   // NOTE: storage has no reset; entries are only ever read when count says they are valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[pop_ok ? sp_dec : sp] <= din;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sp    <= '0;
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (pop_ok && !push) begin
         sp    <= sp_dec;
         count <= count - CW'(1);
      end else if (push && !pop_ok) begin
         sp <= sp_inc;
         if (!full) count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: prioritised next-PC select, EPC capture and redirect pulse.
// Define PC_RAS_EN to build the return-address stack that predicts jr $ra targets.
module pc_unit import pc_pkg::*; #(
   parameter int               WIDTH     = DEF_WIDTH,
   parameter int               INC       = DEF_INC,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
   parameter int               RAS_DEPTH = 4
) (
   input logic  clk,
   input logic  rst,
   pc_if.slave  bus
);

   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] epc_q;
   logic             redirect_q;
   logic [WIDTH-1:0] pc_plus;
   logic [WIDTH-1:0] pc_next;
   logic [WIDTH-1:0] ret_pc;
   logic             stack_go;
   pc_sel_e          sel;

   assign pc_plus  = pc_q + WIDTH'(INC);
   // Stack only moves when the ID-stage decode actually advances.
   assign stack_go = !bus.exc && !bus.br_taken && !bus.stall;

`ifdef PC_RAS_EN
   logic [WIDTH-1:0] ras_top;
   logic             ras_empty;
   logic             unused_full;

   pc_ras #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .rst   (rst),
      .push  (stack_go && bus.call),
      .pop   (stack_go && bus.ret),
      .clear (bus.exc),
      .din   (bus.call_ret_addr),
      .top   (ras_top),
      .empty (ras_empty),
      .full  (unused_full)
   );

   assign ret_pc        = ras_empty ? bus.ret_target : ras_top;
   assign bus.ras_empty = ras_empty;
`else
   logic unused_ras;
   assign unused_ras    = ^{bus.call, bus.call_ret_addr, (RAS_DEPTH > 1)};
   assign ret_pc        = bus.ret_target;
   assign bus.ras_empty = 1'b1;
`endif

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      sel = SEL_SEQ;
      if      (rst)          sel = SEL_RST;
      else if (bus.exc)      sel = SEL_EXC;
      else if (bus.br_taken) sel = SEL_BR;
      else if (bus.stall)    sel = SEL_HOLD;
      else if (bus.jump)     sel = SEL_JMP;
      else if (bus.ret)      sel = SEL_RET;
   end

   always_comb begin
      pc_next = pc_plus;
      unique case (sel)
         SEL_RST:  pc_next = RESET_VEC;
         SEL_EXC:  pc_next = EXC_VEC;
         SEL_BR:   pc_next = bus.br_target;
         SEL_HOLD: pc_next = pc_q;
         SEL_JMP:  pc_next = bus.jump_target;
         SEL_RET:  pc_next = ret_pc;
         default:  pc_next = pc_plus;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RESET_VEC;
         epc_q      <= '0;
         redirect_q <= 1'b0;
      end else begin
         pc_q       <= pc_next;
         redirect_q <= is_redirect(sel);
         if (sel == SEL_EXC) epc_q <= bus.exc_pc;
      end
   end

   assign bus.pc       = pc_q;
   assign bus.pc_plus  = pc_plus;
   assign bus.epc      = epc_q;
   assign bus.redirect = redirect_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: the driver pushes reference-model expectations,
// a monitor pops and compares them one edge later. Follows PC_RAS_EN if defined.
module tb_pc_unit;

   localparam int          W         = 32;
   localparam int          INC       = 4;
   localparam int          DEPTH     = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_0000;
   localparam logic [31:0] EXC_VEC   = 32'h0000_0080;

   logic clk = 1'b0;
   logic rst = 1'b1;

   pc_if #(.WIDTH(W)) bus();

   pc_unit #(
      .WIDTH(W), .INC(INC), .RESET_VEC(RESET_VEC), .EXC_VEC(EXC_VEC), .RAS_DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        stall;
      logic        exc;
      logic [31:0] exc_pc;
      logic        br;
      logic [31:0] br_target;
      logic        jump;
      logic [31:0] jump_target;
      logic        call;
      logic [31:0] call_addr;
      logic        ret;
      logic [31:0] ret_target;
   } stim_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] epc;
      logic        redirect;
      logic        ras_empty;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_pc;
   logic [31:0] m_epc;
   logic        m_red;
   logic [31:0] m_stack[$];   // back = most recent return address
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   // Reference behaviour: priority list from the top down, stack as a bounded queue.
   task automatic model(input stim_t s);
      logic [31:0] tgt;
      if (s.rst) begin
         m_pc  = RESET_VEC;
         m_epc = 32'h0;
         m_red = 1'b0;
         m_stack.delete();
      end else if (s.exc) begin
         m_pc  = EXC_VEC;
         m_epc = s.exc_pc;
         m_red = 1'b1;
         m_stack.delete();
      end else if (s.br) begin
         m_pc  = s.br_target;
         m_red = 1'b1;
      end else if (s.stall) begin
         m_red = 1'b0;
      end else begin
         tgt = s.ret_target;
`ifdef PC_RAS_EN
         if (s.ret && m_stack.size() > 0) tgt = m_stack.pop_back();
         if (s.call) begin
            m_stack.push_back(s.call_addr);
            if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
         end
`endif
         if (s.jump)     m_pc = s.jump_target;
         else if (s.ret) m_pc = tgt;
         else            m_pc = m_pc + INC;
         m_red = s.jump || s.ret;
      end
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      @(negedge clk);
      rst               = s.rst;
      bus.stall         = s.stall;
      bus.exc           = s.exc;
      bus.exc_pc        = s.exc_pc;
      bus.br_taken      = s.br;
      bus.br_target     = s.br_target;
      bus.jump          = s.jump;
      bus.jump_target   = s.jump_target;
      bus.call          = s.call;
      bus.call_ret_addr = s.call_addr;
      bus.ret           = s.ret;
      bus.ret_target    = s.ret_target;
      model(s);
      e.pc        = m_pc;
      e.epc       = m_epc;
      e.redirect  = m_red;
      e.ras_empty = (m_stack.size() == 0);
      exp_q.push_back(e);
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.rst         = ($urandom_range(63) == 0);
      s.exc         = ($urandom_range(15) == 0);
      s.exc_pc      = $urandom();
      s.br          = ($urandom_range(7) == 0);
      s.br_target   = $urandom();
      s.stall       = ($urandom_range(3) == 0);
      s.jump        = ($urandom_range(5) == 0);
      s.jump_target = $urandom();
      s.call        = ($urandom_range(3) == 0);
      s.call_addr   = $urandom();
      s.ret         = ($urandom_range(3) == 0);
      s.ret_target  = $urandom();
      return s;
   endfunction

   // Monitor: every edge presents a new PC state, so consume one expectation per edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pc",        bus.pc,               e.pc);
            check("pc_plus",   bus.pc_plus,          e.pc + INC);
            check("epc",       bus.epc,              e.epc);
            check("redirect",  32'(bus.redirect),    32'(e.redirect));
            check("ras_empty", 32'(bus.ras_empty),   32'(e.ras_empty));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d pending, expected completion", exp_q.size());
      $fatal(1);
   end

   initial begin
      stim_t s;
      bus.stall = 1'b0; bus.exc = 1'b0; bus.exc_pc = '0; bus.br_taken = 1'b0;
      bus.br_target = '0; bus.jump = 1'b0; bus.jump_target = '0; bus.call = 1'b0;
      bus.call_ret_addr = '0; bus.ret = 1'b0; bus.ret_target = '0;

      s = idle(); s.rst = 1'b1; step(s);
      repeat (4) step(idle());                         // 0x4, 0x8, 0xC, 0x10

      s = idle(); s.stall = 1'b1; s.jump = 1'b1; s.jump_target = 32'h400;
      step(s); step(s);                                // hold 0x10
      s.stall = 1'b0; step(s);                         // 0x400, redirect
      step(idle());

      s = idle(); s.stall = 1'b1; s.br = 1'b1; s.br_target = 32'h200;
      s.jump = 1'b1; s.jump_target = 32'h600;
      step(s);                                         // 0x200
      s.exc = 1'b1; s.exc_pc = 32'h44; step(s);        // 0x80, epc 0x44

      s = idle(); s.jump = 1'b1; s.call = 1'b1;
      s.jump_target = 32'h1000; s.call_addr = 32'h104; step(s);
      s.jump_target = 32'h2000; s.call_addr = 32'h204; step(s);
      s = idle(); s.ret = 1'b1; s.ret_target = 32'hDEAD_BEE0;
      step(s); step(s);
      s.ret_target = 32'h900; step(s);

      s = idle(); s.call = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         s.call_addr = 32'(i * 16);
         step(s);
      end
      s = idle(); s.ret = 1'b1;
      for (int i = 0; i < 5; i++) begin
         s.ret_target = 32'h0000_0A00 + 32'(i * 4);
         step(s);
      end

      s = idle(); s.jump = 1'b1; s.jump_target = 32'hFFFF_FFFC; step(s);
      step(idle());                                    // wraps to 0x0
      s = idle(); s.rst = 1'b1; s.br = 1'b1; s.br_target = 32'h300; s.exc = 1'b1;
      step(s);
      step(idle());

      for (int i = 0; i < 400; i++) step(rand_stim());

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the pipelined MIPS core; successor to the single-register counter. Owns the fetch address and selects the next PC from sequential increment, branch, jump, return and exception sources, with a fixed priority and stall handling. Drives the IF-stage instruction address and reports redirects so IF/ID can be flushed. An optional return-address stack predicts `jr $ra` targets.

## Interface
Parameters:
- `WIDTH`, 32, address width in bits
- `INC`, 4, sequential increment in bytes
- `RESET_VEC`, 0, PC value after reset
- `EXC_VEC`, 32'h0000_0080, exception handler address
- `RAS_DEPTH`, 4, return-stack entries (≥2); used only with `PC_RAS_EN`

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hazard stall from hazard unit; holds PC
- `exc`  in  1  exception request from MEM stage
- `exc_pc`  in  WIDTH  PC of the faulting instruction
- `br_taken`  in  1  branch resolved taken in EX
- `br_target`  in  WIDTH  branch target
- `jump`  in  1  J/JAL decoded in ID
- `jump_target`  in  WIDTH  jump target
- `call`  in  1  JAL/JALR decoded in ID (push request)
- `call_ret_addr`  in  WIDTH  return address to push
- `ret`  in  1  `jr $ra` decoded in ID
- `ret_target`  in  WIDTH  register-file value of `$ra`
- `pc`  out  WIDTH  current fetch address (registered)
- `pc_plus`  out  WIDTH  `pc + INC` (combinational)
- `epc`  out  WIDTH  captured exception PC (registered)
- `redirect`  out  1  registered pulse: PC changed non-sequentially last cycle
- `ras_empty`  out  1  return stack empty (tied 1 without `PC_RAS_EN`)

## Operation
- Next-PC priority, highest first: `rst` → `RESET_VEC`; `exc` → `EXC_VEC`; `br_taken` → `br_target`; `stall` → hold; `jump` → `jump_target`; `ret` → return target; else `pc + INC`.
- `exc` and `br_taken` override `stall` (sources downstream of the stall point). `jump`, `ret`, `call` are ignored while `stall`=1.
- `epc` loads `exc_pc` on the `exc` edge; otherwise holds.
- `redirect` is 1 in the cycle after any exc/branch/jump/ret update, else 0. A hold is not a redirect.
- All additions are modulo 2^WIDTH; `pc + INC` wraps from all-ones without flag.
- Return target: top of stack when `PC_RAS_EN` and stack non-empty; otherwise `ret_target`.

## Timing
- Reset values: `pc`=`RESET_VEC`, `epc`=0, `redirect`=0, stack count=0, `ras_empty`=1.
- One-cycle latency: a source asserted in cycle N appears on `pc` in cycle N+1.
- `pc_plus` follows `pc` combinationally in the same cycle.
- Stack ops take effect only when the PC update is not blocked by stall and no higher-priority redirect (exc/br) occurs that cycle.
- Simultaneous `call` and `ret`: pop then push (top replaced, count unchanged).
- Push on full: overwrite oldest entry (circular), count saturates at `RAS_DEPTH`.
- Pop on empty: no state change, target = `ret_target`.
- `exc` clears stack count to 0. `br_taken` leaves the stack intact.
- `rst` mid-operation overrides every input the same edge.

## Configuration
- `PC_RAS_EN` defined: return-address stack of `RAS_DEPTH` entries built; `ret` redirects to predicted top-of-stack.
- Not defined: no stack storage; `ret` redirects to `ret_target`; `call` ignored; `ras_empty` tied 1.

## Structure
- Shared package `pc_pkg`: next-PC select enum (`SEL_RST`, `SEL_EXC`, `SEL_BR`, `SEL_HOLD`, `SEL_JMP`, `SEL_RET`, `SEL_SEQ`), default `EXC_VEC`, `INC`.
- One sub-module `pc_ras`: circular stack with push/pop/clear, top, empty/full; instantiated only under `PC_RAS_EN`.
- Top holds priority mux, `pc`/`epc`/`redirect` registers.

## Test plan
- Reset, 3 free-running cycles → `pc` 0x0, 0x4, 0x8, 0xC; `redirect`=0.
- `pc`=0x10, `stall`=1 for 2 cycles with `jump`=1 (target 0x400) → `pc` holds 0x10; release stall with jump still high → `pc`=0x400, `redirect`=1 next cycle.
- `stall`=1, `br_taken`=1 target 0x200, `jump`=1 → `pc`=0x200; with `exc`=1 also, `exc_pc`=0x44 → `pc`=0x80, `epc`=0x44.
- (`PC_RAS_EN`, depth 4) call pushes 0x104, 0x204; two rets → `pc` 0x204 then 0x104; third ret, `ret_target`=0x900 → `pc`=0x900, `ras_empty`=1.
- (`PC_RAS_EN`) five pushes 0x10..0x50 → pops yield 0x50, 0x40, 0x30, 0x20, then fallback to `ret_target`.
- `pc`=0xFFFF_FFFC sequential → `pc`=0x0; `rst` asserted during branch → `pc`=`RESET_VEC`, `redirect`=0.
